hamming_secded_correct_pipe: RTL
================================

HAMMING_SECDED_CORRECT_PIPE -- requirements
Module: hamming_secded_correct_pipe

Interface
REQ-001 Parameter K, default 11: data bits; legal values 4, 11, 26, 57; any other value SHALL fail elaboration.
REQ-002 Parameter R, derived: Hamming check bits, 3/4/5/6 for K = 4/11/26/57; not user-overridable.
REQ-003 Parameter N, derived: codeword width, K+R+1, including the overall parity bit.
REQ-004 Parameter CNT_W, default 16: width of each error counter, 2..32.
REQ-005 Port clk, in, 1: single clock; all logic is on its rising edge.
REQ-006 Port rst, in, 1: synchronous, active-high reset.
REQ-007 Port valid_i, in, 1: codeword_i is valid.
REQ-008 Port ready_o, out, 1: block accepts an input this cycle.
REQ-009 Port codeword_i, in, N: bit 0 is overall parity; bits 1..N-1 are Hamming positions; power-of-two positions hold check bits, the rest hold data LSB-first.
REQ-010 Port valid_o, out, 1: outputs are valid.
REQ-011 Port ready_i, in, 1: downstream accepts the output.
REQ-012 Port data_o, out, K: corrected data.
REQ-013 Port sec_o, out, 1: single error was corrected.
REQ-014 Port ded_o, out, 1: uncorrectable error; data_o is uncorrected.
REQ-015 Port syndrome_o, out, R+1: {overall parity, Hamming syndrome}.
REQ-016 Port clear_cnt_i, in, 1: synchronous clear of both counters.
REQ-017 Ports sec_cnt_o and ded_cnt_o, out, CNT_W each: saturating event counts.

Function
REQ-018 Pipeline: two stages, S1 (syndrome and parity) and S2 (correction and classification); latency from input transfer to valid_o SHALL be exactly 2 cycles with no backpressure.
REQ-019 Advance enable: en = !valid_o || ready_i; both stages move only when en=1; ready_o = en.
REQ-020 Transfer rules: input transfer = valid_i && ready_o; output transfer = valid_o && ready_i; when en=1, S1 valid bubbles propagate.
REQ-021 Stall: while valid_o=1 and ready_i=0, all outputs SHALL hold stable; no word is lost, duplicated or reordered.
REQ-022 Syndrome s SHALL be the XOR of the indices of all set bits at positions 1..N-1; overall parity p SHALL be the XOR of all N bits.
REQ-023 Case s=0, p=0: clean; sec_o=0, ded_o=0.
REQ-024 Case p=1, s=0: the error is in the parity bit; sec_o=1; data unchanged.
REQ-025 Case p=1, 0<s<=N-1: flip position s; sec_o=1.
REQ-026 Case p=1, s>N-1: ded_o=1, sec_o=0.
REQ-027 Case s!=0, p=0: double error; ded_o=1, sec_o=0; data is passed uncorrected.
REQ-028 sec_o and ded_o SHALL never both be 1.
REQ-029 Counters SHALL increment only on an output transfer with sec_o or ded_o set, and SHALL saturate at 2^CNT_W-1.
REQ-030 If clear_cnt_i=1 in the same cycle as an event, the clear wins and the counter becomes 0.

Reset
REQ-031 While rst=1: S1/S2 valid=0, valid_o=0, data_o=0, sec_o=0, ded_o=0, syndrome_o=0, both counters=0.
REQ-032 ready_o SHALL be 1 from the first cycle after reset.
REQ-033 Reset mid-stream SHALL flush all in-flight words; none of them reappears after reset.

Structure
REQ-034 Package hamming_pkg SHALL hold: the function r_of_k(K), the legal-K check, typedef enum err_class_t {CLEAN, SEC, DED}, and the position-to-data-index mapping function.
REQ-035 Sub-module hamming_syndrome_calc #(N,R): combinational; codeword to {p,s}; instantiated in S1.

Verification (K=11, N=16, CNT_W=4 unless stated)
REQ-036 Clean encode of data 0x5A5, valid_i pulse, ready_i=1 -> 2 cycles later valid_o=1, data_o=0x5A5, sec_o=0, ded_o=0, syndrome_o=0.
REQ-037 Same codeword with position 5 flipped -> sec_o=1, syndrome_o=5'b1_0101, data_o=0x5A5, sec_cnt_o=1.
REQ-038 Positions 3 and 6 flipped -> ded_o=1, syndrome_o=5'b0_0101, ded_cnt_o=1, sec_cnt_o unchanged.
REQ-039 Back-to-back stream of 4 words, ready_i low 3 cycles mid-stream -> ready_o low while stalled, outputs stable, all 4 delivered in order.
REQ-040 17 single-error words -> sec_cnt_o=15; clear_cnt_i asserted in the same cycle as an event -> sec_cnt_o=0 next cycle.
REQ-041 rst pulsed with 2 words in flight -> valid_o=0 next cycle, counters=0, no stale output afterwards; repeat for K=4 and K=57.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED correction pipeline: check-bit count,
// legal data widths, error classes and codeword position mapping.
package hamming_pkg;

    typedef enum logic [1:0] {
        CLEAN,
        SEC,
        DED
    } err_class_t;

    function automatic int r_of_k(input int k);
        int r;
        case (k)
            4:       r = 3;
            11:      r = 4;
            26:      r = 5;
            57:      r = 6;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic bit k_is_legal(input int k);
        return r_of_k(k) != 0;
    endfunction

    // Data bit idx lives at the idx-th non-power-of-two Hamming position.
    function automatic int data_pos(input int idx);
        int result;
        int cnt;
        result = 0;
        cnt    = 0;
        for (int pos = 1; pos < 128; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (cnt == idx) begin
                    result = pos;
                end
                cnt++;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational syndrome and overall-parity computation for one codeword.
module hamming_syndrome_calc #(
    parameter int N = 16,
    parameter int R = 4
) (
    input  logic [N-1:0] codeword,
    output logic         parity,
    output logic [R-1:0] syndrome
);

    always_comb begin
        syndrome = '0;
        for (int i = 1; i < N; i++) begin
            if (codeword[i]) begin
                syndrome = syndrome ^ R'(i);
            end
        end
    end

    assign parity = ^codeword;

endmodule

// File: rtl/hamming_secded_correct_pipe.sv
// Two-stage SECDED decoder: S1 computes syndrome/parity, S2 corrects and
// classifies; valid/ready handshake with saturating error counters.
module hamming_secded_correct_pipe
    import hamming_pkg::*;
#(
    parameter int  K     = 11,
    parameter int  CNT_W = 16,
    localparam int R     = r_of_k(K),
    localparam int N     = K + R + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [N-1:0]     codeword_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [K-1:0]     data_o,
    output logic             sec_o,
    output logic             ded_o,
    output logic [R:0]       syndrome_o,
    input  logic             clear_cnt_i,
    output logic [CNT_W-1:0] sec_cnt_o,
    output logic [CNT_W-1:0] ded_cnt_o
);

    if (!k_is_legal(K)) begin : g_illegal_k
        $fatal(1, "hamming_secded_correct_pipe: K must be 4, 11, 26 or 57");
    end
    if (CNT_W < 2 || CNT_W > 32) begin : g_illegal_cnt_w
        $fatal(1, "hamming_secded_correct_pipe: CNT_W must be 2..32");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic         en;
    logic         out_xfer;
    logic         calc_parity;
    logic [R-1:0] calc_syndrome;
    logic [K-1:0] data_in;

    logic         s1_valid;
    logic [K-1:0] s1_data;
    logic         s1_parity;
    logic [R-1:0] s1_syndrome;

    err_class_t   err_class;
    logic         flip_en;
    logic [K-1:0] data_next;

    assign en       = !valid_o || ready_i;
    assign ready_o  = en;
    assign out_xfer = valid_o && ready_i;

    hamming_syndrome_calc #(
        .N(N),
        .R(R)
    ) u_syndrome (
        .codeword(codeword_i),
        .parity  (calc_parity),
        .syndrome(calc_syndrome)
    );

    // Only data positions need carrying forward; check bits are fully
    // summarised by the syndrome.
    for (genvar j = 0; j < K; j++) begin : g_extract
        assign data_in[j] = codeword_i[data_pos(j)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_parity   <= 1'b0;
            s1_syndrome <= '0;
        end else if (en) begin
            s1_valid    <= valid_i;
            s1_data     <= data_in;
            s1_parity   <= calc_parity;
            s1_syndrome <= calc_syndrome;
        end
    end

    always_comb begin
        err_class = CLEAN;
        if (s1_parity) begin
            if (int'(s1_syndrome) <= N - 1) begin
                err_class = SEC;
            end else begin
                err_class = DED;
            end
        end else if (s1_syndrome != '0) begin
            err_class = DED;
        end
    end

    assign flip_en = (err_class == SEC);

    // A zero syndrome with SEC means the parity bit itself flipped, which
    // never matches a data position, so data passes through untouched.
    for (genvar j = 0; j < K; j++) begin : g_correct
        assign data_next[j] = s1_data[j] ^ (flip_en && (s1_syndrome == R'(data_pos(j))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            data_o     <= '0;
            sec_o      <= 1'b0;
            ded_o      <= 1'b0;
            syndrome_o <= '0;
        end else if (en) begin
            valid_o    <= s1_valid;
            data_o     <= data_next;
            sec_o      <= s1_valid && (err_class == SEC);
            ded_o      <= s1_valid && (err_class == DED);
            syndrome_o <= {s1_parity, s1_syndrome};
        end
    end

    // Clear takes priority over a coincident event.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt_i) begin
            sec_cnt_o <= '0;
            ded_cnt_o <= '0;
        end else begin
            if (out_xfer && sec_o && sec_cnt_o != CNT_MAX) begin
                sec_cnt_o <= sec_cnt_o + CNT_W'(1);
            end
            if (out_xfer && ded_o && ded_cnt_o != CNT_MAX) begin
                ded_cnt_o <= ded_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
